cfi_event_sched: RTL and testbench
==================================

# cfi_event_sched

Sequencer between the commit stage and the single shadow-stack check port used by the Control-Flow Integrity logic. Control-flow events (calls and returns) retire on up to NR_COMMIT_PORTS commit ports per cycle. They are buffered in order in a small FIFO and issued one at a time over a valid/ready request plus response handshake. The block stalls commit through `cfi_wait_o` when the buffer cannot absorb a full commit bundle. It holds a sticky fault until the pipeline flushes.

## Interface
- `NR_COMMIT_PORTS`, default 2: number of commit ports sampled per cycle.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥ NR_COMMIT_PORTS.
- `VLEN`, default 64: event address width.
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `evt_valid_i`, in, NR_COMMIT_PORTS: per-port event retiring this cycle.
- `evt_is_ret_i`, in, NR_COMMIT_PORTS: 1 = return, 0 = call.
- `evt_addr_i`, in, NR_COMMIT_PORTS×VLEN: per-port return address (call) or target (return).
- `flush_i`, in, 1: pipeline flush; clears pending events and any fault.
- `chk_valid_o`, out, 1: check request valid.
- `chk_is_ret_o`, out, 1: request type.
- `chk_addr_o`, out, VLEN: request address.
- `chk_ready_i`, in, 1: check unit accepts the request.
- `rsp_valid_i`, in, 1: check result valid.
- `rsp_fault_i`, in, 1: the check failed.
- `cfi_wait_o`, out, 1: commit must not retire control-flow events this cycle.
- `cfi_fault_valid_o`, out, 1: sticky CFI violation.
- `cfi_fault_tval_o`, out, VLEN: address of the faulting event.

## Operation
- **FIFO**
  - In-order FIFO with pointers of $clog2(DEPTH) bits that wrap naturally, plus a count of $clog2(DEPTH+1) bits.
  - Push: all valid ports are pushed in one cycle, lower port index first, so the lower index lands at the older entry. Invalid ports leave no holes.
  - Pushes are accepted only when `cfi_wait_o` = 0. Valid events arriving while `cfi_wait_o` = 1 are ignored.
  - Push and pop may occur in the same cycle. The count updates by pushes − pops.
- **`cfi_wait_o`** is combinational from registered state: it is 1 when (DEPTH − count) < NR_COMMIT_PORTS, or when state is FAULT or DRAIN.
- **FSM states**
  - IDLE:
    - `chk_valid_o` = 1 when the FIFO is not empty, driven with the head entry's type and address.
    - On `chk_valid_o && chk_ready_i`: pop the head, latch its address into the in-flight register, go to WAIT_RSP.
  - WAIT_RSP:
    - `chk_valid_o` = 0.
    - On `rsp_valid_i && !rsp_fault_i`: go to IDLE.
    - On `rsp_valid_i && rsp_fault_i`: load `cfi_fault_tval_o` from the in-flight register, go to FAULT.
  - FAULT:
    - `cfi_fault_valid_o` = 1. The FIFO is frozen and no requests are issued.
    - Only `flush_i` leaves this state.
  - DRAIN:
    - Waits for the response of a check that was in flight when the flush arrived.
    - On `rsp_valid_i`: discard the response (a fault is ignored) and go to IDLE.
- **`flush_i`** (highest priority after reset):
  - Empties the FIFO (pointers and count to 0) and clears `cfi_fault_valid_o`.
  - Events presented in the same cycle as the flush are dropped.
  - Next state: DRAIN if the current state is WAIT_RSP and `rsp_valid_i` = 0 this cycle; otherwise IDLE.
  - A handshake in IDLE in the same cycle as the flush is not taken: `chk_valid_o` is forced to 0 while `flush_i` = 1.
- `rsp_valid_i` in IDLE or FAULT is a protocol error and is ignored.

## Timing
- **Reset values:** state IDLE, count 0, pointers 0, `chk_valid_o` 0, `chk_is_ret_o` 0, `chk_addr_o` 0, `cfi_wait_o` 0, `cfi_fault_valid_o` 0, `cfi_fault_tval_o` 0.
- Reset applied mid-operation behaves like a flush with no DRAIN: it returns to IDLE and a later stray response is ignored.
- **Latency:**
  - Event pushed in cycle t appears on `chk_valid_o` at t+1 at the earliest (FIFO was empty, state IDLE).
  - Request handshake at t means the response is accepted from t+1 at the earliest.
  - A clean response at t means the next request is valid at t+1.
  - Maximum throughput is one check per 2 cycles.
- `chk_valid_o` is stable (no withdrawal) and its payload does not change until ready, except on flush.
- A fault response at t gives `cfi_fault_valid_o` = 1 and `cfi_wait_o` = 1 from t+1.
- `flush_i` at t gives count 0 and `cfi_fault_valid_o` = 0 at t+1.
- Full boundary:
  - With DEPTH = 4 and NR = 2, `cfi_wait_o` rises when count ≥ 3.
  - A pop in the same cycle does not lower `cfi_wait_o` until the next cycle.

## Test plan
- **Ordered push:** with rst_i, then both ports valid (call 0x100 on port 0, return 0x200 on port 1) and chk_ready_i = 1 with responses 1 cycle later → requests issue as 0x100/call then 0x200/ret, at cycles t+1 and t+3.
- **Full/wait:** chk_ready_i = 0 and 2 events per cycle for 2 cycles → count = 4 and `cfi_wait_o` = 1. A third bundle is ignored. After a single pop and response, `cfi_wait_o` = 0 only once count ≤ 2.
- **Fault:** the second check (addr 0x2A0) returns rsp_fault_i = 1 → `cfi_fault_valid_o` = 1 with tval = 0x2A0, no further `chk_valid_o` although the FIFO holds 1 entry, `cfi_wait_o` = 1. flush_i → all cleared next cycle.
- **Flush in WAIT_RSP:** handshake, then flush_i with no response, then rsp_valid_i with rsp_fault_i = 1 two cycles later → no fault raised, state IDLE afterwards. New events are accepted only after the discarded response.
- **Simultaneous push/pop:** count = 2, then a handshake plus one pushed event in the same cycle → count = 2 next cycle. Order is preserved across pointer wrap (20 events with incrementing addresses all checked in order).
- **Reset mid-stream:** rst_i asserted while in WAIT_RSP with 3 entries queued → all outputs at reset values next cycle. A following stray rsp_valid_i is ignored.

Source files
------------

// File: rtl/cfi_event_sched_if.sv
// Check-port handshake between the CFI event sequencer (master) and the
// shadow-stack check unit (slave): request valid/ready plus a response strobe.
interface cfi_event_sched_if #(
    parameter int VLEN = 64
) ();
    logic            chk_valid;
    logic            chk_is_ret;
    logic [VLEN-1:0] chk_addr;
    logic            chk_ready;
    logic            rsp_valid;
    logic            rsp_fault;

    modport master (
        output chk_valid, chk_is_ret, chk_addr,
        input  chk_ready, rsp_valid, rsp_fault
    );

    modport slave (
        input  chk_valid, chk_is_ret, chk_addr,
        output chk_ready, rsp_valid, rsp_fault
    );
endinterface

// File: rtl/cfi_event_sched.sv
// Buffers retired call/return events in order and issues them one at a time to
// the shadow-stack check port; stalls commit when full and holds a sticky fault.
module cfi_event_sched #(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int DEPTH           = 4,
    parameter int VLEN            = 64
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NR_COMMIT_PORTS-1:0]      evt_valid_i,
    input  logic [NR_COMMIT_PORTS-1:0]      evt_is_ret_i,
    input  logic [NR_COMMIT_PORTS*VLEN-1:0] evt_addr_i,
    input  logic                            flush_i,
    cfi_event_sched_if.master               chk_if,
    output logic                            cfi_wait_o,
    output logic                            cfi_fault_valid_o,
    output logic [VLEN-1:0]                 cfi_fault_tval_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    // Stall once fewer than a full bundle of free slots remain.
    localparam logic [CNT_W-1:0] WAIT_THR = CNT_W'(DEPTH - NR_COMMIT_PORTS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VLEN-1:0]  tval_q, tval_d;
    logic [VLEN-1:0]  inflight_q;

    logic [VLEN-1:0]  addr_mem_q [DEPTH];
    logic [DEPTH-1:0] ret_mem_q;

    logic                       head_vld;
    logic                       pop;
    logic                       push_en;
    logic [CNT_W-1:0]           push_cnt;
    logic [PTR_W-1:0]           slot_idx [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0] slot_we;

    assign cfi_wait_o = (cnt_q >= WAIT_THR) || (state_q == S_FAULT) || (state_q == S_DRAIN);
    assign push_en    = !cfi_wait_o && !flush_i;

    // A flush suppresses the request so no handshake can complete alongside it.
    assign head_vld          = (state_q == S_IDLE) && (cnt_q != '0) && !flush_i;
    assign pop               = head_vld && chk_if.chk_ready;
    assign chk_if.chk_valid  = head_vld;
    assign chk_if.chk_is_ret = head_vld & ret_mem_q[rd_ptr_q];
    assign chk_if.chk_addr   = head_vld ? addr_mem_q[rd_ptr_q] : '0;

    assign cfi_fault_valid_o = (state_q == S_FAULT);
    assign cfi_fault_tval_o  = tval_q;

    // Compact valid ports into consecutive slots, lower port index oldest.
    always_comb begin
        push_cnt = '0;
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            slot_idx[p] = wr_ptr_q + PTR_W'(push_cnt);
            slot_we[p]  = push_en && evt_valid_i[p];
            if (slot_we[p]) begin
                push_cnt = push_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tval_d   = tval_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q + push_cnt - CNT_W'(pop);
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (chk_if.rsp_valid) begin
                    if (chk_if.rsp_fault) begin
                        state_d = S_FAULT;
                        tval_d  = inflight_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FAULT: state_d = S_FAULT;
            S_DRAIN: begin
                if (chk_if.rsp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A check still outstanding at flush must have its response swallowed.
        if (flush_i) begin
            state_d  = ((state_q == S_WAIT) && !chk_if.rsp_valid) ? S_DRAIN : S_IDLE;
            tval_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            tval_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            tval_q   <= tval_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (pop) begin
            inflight_q <= addr_mem_q[rd_ptr_q];
        end
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (slot_we[p]) begin
                addr_mem_q[slot_idx[p]] <= evt_addr_i[p*VLEN +: VLEN];
                ret_mem_q[slot_idx[p]]  <= evt_is_ret_i[p];
            end
        end
    end

endmodule

// File: tb/tb_cfi_event_sched.sv
// Directed bench for cfi_event_sched: a vector table for the single-cycle
// behaviour plus hand sequences for flush-drain, pointer wrap and reset.
module tb_cfi_event_sched;
    localparam int NR    = 2;
    localparam int DEPTH = 4;
    localparam int VLEN  = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  evt_valid;
    logic [NR-1:0]  evt_is_ret;
    logic [NR*VLEN-1:0] evt_addr;
    logic           flush;
    logic           cfi_wait;
    logic           fault_valid;
    logic [VLEN-1:0] fault_tval;

    cfi_event_sched_if #(.VLEN(VLEN)) chk_if ();

    cfi_event_sched #(
        .NR_COMMIT_PORTS(NR),
        .DEPTH(DEPTH),
        .VLEN(VLEN)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .evt_valid_i(evt_valid),
        .evt_is_ret_i(evt_is_ret),
        .evt_addr_i(evt_addr),
        .flush_i(flush),
        .chk_if(chk_if),
        .cfi_wait_o(cfi_wait),
        .cfi_fault_valid_o(fault_valid),
        .cfi_fault_tval_o(fault_tval)
    );

    always #5 clk = ~clk;

    // ctl = {flush, chk_ready, rsp_valid, rsp_fault}; ex = {chk_valid, chk_is_ret, cfi_wait, fault_valid}
    typedef struct {
        logic [1:0]  v;
        logic [1:0]  r;
        logic [63:0] a0;
        logic [63:0] a1;
        logic [3:0]  ctl;
        logic [3:0]  ex;
        logic [63:0] ca;
        logic [63:0] tv;
    } vec_t;

    vec_t vecs [28];
    int n_chk  = 0;
    int n_fail = 0;

    function automatic vec_t mk(logic [1:0] v, logic [1:0] r, logic [63:0] a0, logic [63:0] a1,
                                logic [3:0] ctl, logic [3:0] ex, logic [63:0] ca, logic [63:0] tv);
        vec_t t;
        t.v = v; t.r = r; t.a0 = a0; t.a1 = a1; t.ctl = ctl; t.ex = ex; t.ca = ca; t.tv = tv;
        return t;
    endfunction

    task automatic check1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic [1:0] v, input logic [1:0] r, input logic [63:0] a0,
                         input logic [63:0] a1, input logic [3:0] ctl);
        evt_valid        = v;
        evt_is_ret       = r;
        evt_addr         = {a1, a0};
        flush            = ctl[3];
        chk_if.chk_ready = ctl[2];
        chk_if.rsp_valid = ctl[1];
        chk_if.rsp_fault = ctl[0];
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] r, input logic [63:0] a0,
                        input logic [63:0] a1, input logic [3:0] ctl);
        @(negedge clk);
        apply(v, r, a0, a1, ctl);
        #2;
    endtask

    task automatic check_reset_outs(input string tag);
        check1({tag, ".chk_valid"}, chk_if.chk_valid, 1'b0);
        check1({tag, ".chk_is_ret"}, chk_if.chk_is_ret, 1'b0);
        check64({tag, ".chk_addr"}, chk_if.chk_addr, 64'h0);
        check1({tag, ".cfi_wait"}, cfi_wait, 1'b0);
        check1({tag, ".fault_valid"}, fault_valid, 1'b0);
        check64({tag, ".fault_tval"}, fault_tval, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int got;
        logic pend;

        vecs[0]  = mk(2'b11, 2'b10, 64'h100, 64'h200, 4'b0100, 4'b0000, 64'h0,   64'h0);
        vecs[1]  = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0100, 4'b1000, 64'h100, 64'h0);
        vecs[2]  = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0010, 4'b0000, 64'h0,   64'h0);
        vecs[3]  = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0100, 4'b1100, 64'h200, 64'h0);
        vecs[4]  = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0010, 4'b0000, 64'h0,   64'h0);
        vecs[5]  = mk(2'b11, 2'b00, 64'h300, 64'h310, 4'b0000, 4'b0000, 64'h0,   64'h0);
        vecs[6]  = mk(2'b11, 2'b11, 64'h320, 64'h330, 4'b0000, 4'b1000, 64'h300, 64'h0);
        vecs[7]  = mk(2'b11, 2'b11, 64'h340, 64'h350, 4'b0000, 4'b1010, 64'h300, 64'h0);
        vecs[8]  = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0100, 4'b1010, 64'h300, 64'h0);
        vecs[9]  = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0010, 4'b0010, 64'h0,   64'h0);
        vecs[10] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0000, 4'b1010, 64'h310, 64'h0);
        vecs[11] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0100, 4'b1010, 64'h310, 64'h0);
        vecs[12] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0000, 4'b0000, 64'h0,   64'h0);
        vecs[13] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0010, 4'b0000, 64'h0,   64'h0);
        vecs[14] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b1100, 4'b0000, 64'h0,   64'h0);
        vecs[15] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0000, 4'b0000, 64'h0,   64'h0);
        vecs[16] = mk(2'b11, 2'b10, 64'h290, 64'h2A0, 4'b0000, 4'b0000, 64'h0,   64'h0);
        vecs[17] = mk(2'b01, 2'b00, 64'h2B0, 64'h0,   4'b0100, 4'b1000, 64'h290, 64'h0);
        vecs[18] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0010, 4'b0000, 64'h0,   64'h0);
        vecs[19] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0100, 4'b1100, 64'h2A0, 64'h0);
        vecs[20] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0011, 4'b0000, 64'h0,   64'h0);
        vecs[21] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0100, 4'b0011, 64'h0,   64'h2A0);
        vecs[22] = mk(2'b11, 2'b00, 64'h999, 64'h998, 4'b0100, 4'b0011, 64'h0,   64'h2A0);
        vecs[23] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b1000, 4'b0011, 64'h0,   64'h2A0);
        vecs[24] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0000, 4'b0000, 64'h0,   64'h0);
        vecs[25] = mk(2'b10, 2'b10, 64'h0,   64'h500, 4'b0000, 4'b0000, 64'h0,   64'h0);
        vecs[26] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0100, 4'b1100, 64'h500, 64'h0);
        vecs[27] = mk(2'b00, 2'b00, 64'h0,   64'h0,   4'b0010, 4'b0000, 64'h0,   64'h0);

        rst = 1'b1;
        apply(2'b00, 2'b00, 64'h0, 64'h0, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_reset_outs("reset");

        for (int i = 0; i < 28; i++) begin
            step(vecs[i].v, vecs[i].r, vecs[i].a0, vecs[i].a1, vecs[i].ctl);
            check1($sformatf("v%0d.chk_valid", i), chk_if.chk_valid, vecs[i].ex[3]);
            check1($sformatf("v%0d.chk_is_ret", i), chk_if.chk_is_ret, vecs[i].ex[2]);
            check64($sformatf("v%0d.chk_addr", i), chk_if.chk_addr, vecs[i].ca);
            check1($sformatf("v%0d.cfi_wait", i), cfi_wait, vecs[i].ex[1]);
            check1($sformatf("v%0d.fault_valid", i), fault_valid, vecs[i].ex[0]);
            check64($sformatf("v%0d.fault_tval", i), fault_tval, vecs[i].tv);
        end

        // Flush while a check is outstanding: its faulting response must be discarded.
        step(2'b01, 2'b00, 64'h600, 64'h0, 4'b0000);
        check1("drain.pre_valid", chk_if.chk_valid, 1'b0);
        step(2'b00, 2'b00, 64'h0, 64'h0, 4'b0100);
        check64("drain.req_addr", chk_if.chk_addr, 64'h600);
        step(2'b00, 2'b00, 64'h0, 64'h0, 4'b1000);
        check1("drain.flush_valid", chk_if.chk_valid, 1'b0);
        step(2'b01, 2'b00, 64'h700, 64'h0, 4'b0000);
        check1("drain.wait", cfi_wait, 1'b1);
        step(2'b00, 2'b00, 64'h0, 64'h0, 4'b0011);
        check1("drain.wait_at_rsp", cfi_wait, 1'b1);
        step(2'b01, 2'b00, 64'h710, 64'h0, 4'b0000);
        check1("drain.no_fault", fault_valid, 1'b0);
        check1("drain.wait_clear", cfi_wait, 1'b0);
        check1("drain.dropped_evt", chk_if.chk_valid, 1'b0);
        step(2'b00, 2'b00, 64'h0, 64'h0, 4'b0100);
        check1("drain.new_valid", chk_if.chk_valid, 1'b1);
        check64("drain.new_addr", chk_if.chk_addr, 64'h710);
        step(2'b00, 2'b00, 64'h0, 64'h0, 4'b0010);
        check1("drain.done_valid", chk_if.chk_valid, 1'b0);

        // 20 ordered events through the 4-entry FIFO, responses one cycle after each request.
        sent = 0;
        got  = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 400 && (got < 20 || pend); cyc++) begin
            @(negedge clk);
            evt_valid  = '0;
            evt_is_ret = '0;
            evt_addr   = '0;
            if (!cfi_wait) begin
                for (int p = 0; p < NR; p++) begin
                    if (sent < 20 && !(p == 0 && (cyc % 3) == 1)) begin
                        evt_valid[p]            = 1'b1;
                        evt_is_ret[p]           = sent[0];
                        evt_addr[p*VLEN +: VLEN] = 64'h1000 + 64'(sent) * 64'd8;
                        sent++;
                    end
                end
            end
            flush            = 1'b0;
            chk_if.chk_ready = 1'b1;
            chk_if.rsp_valid = pend;
            chk_if.rsp_fault = 1'b0;
            pend             = 1'b0;
            #2;
            if (chk_if.chk_valid) begin
                check64($sformatf("wrap.addr%0d", got), chk_if.chk_addr, 64'h1000 + 64'(got) * 64'd8);
                check1($sformatf("wrap.ret%0d", got), chk_if.chk_is_ret, got[0]);
                got++;
                pend = 1'b1;
            end
        end
        check64("wrap.count", 64'(got), 64'd20);

        // Reset while in WAIT_RSP with three entries queued.
        step(2'b11, 2'b00, 64'h800, 64'h808, 4'b0000);
        check1("rst.pre_valid", chk_if.chk_valid, 1'b0);
        step(2'b01, 2'b00, 64'h810, 64'h0, 4'b0100);
        check64("rst.req_addr", chk_if.chk_addr, 64'h800);
        step(2'b01, 2'b00, 64'h818, 64'h0, 4'b0000);
        check1("rst.wait_cnt2", cfi_wait, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        apply(2'b00, 2'b00, 64'h0, 64'h0, 4'b0000);
        #2;
        check1("rst.wait_cnt3", cfi_wait, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        apply(2'b00, 2'b00, 64'h0, 64'h0, 4'b0011);
        #2;
        check_reset_outs("rst.after");
        step(2'b00, 2'b00, 64'h0, 64'h0, 4'b0000);
        check1("rst.stray_fault", fault_valid, 1'b0);
        check1("rst.stray_wait", cfi_wait, 1'b0);
        check1("rst.stray_valid", chk_if.chk_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
